// File: rtl/instr_fetch_seq_pkg.sv
// Shared CPU fetch definitions: state encoding, default widths and reset PC.
package instr_fetch_seq_pkg;

  localparam int          AW_DEF     = 16;
  localparam int          DW_DEF     = 16;
  localparam logic [15:0] RST_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_seq_fetch_pc_reg.sv
// Program counter register: load beats increment, increment wraps modulo 2^AW.
module fetch_pc_reg
  import instr_fetch_seq_pkg::*;
#(
  parameter int            AW     = AW_DEF,
  parameter logic [AW-1:0] RST_PC = AW'(RST_PC_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          inc,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= RST_PC;
    else if (ld)  q <= d;
    else if (inc) q <= q + AW'(1);
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: issues reads at the PC and hands fetched words
// to decode through a valid/ready handshake, with branch redirect.
//
// state | meaning
// IDLE  | not fetching; waits for start, branches load the PC
// FETCH | read outstanding at mem_addr; waits for mem_ack
// HOLD  | ir holds a valid instruction; waits for ir_ready or a branch
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int            AW     = AW_DEF,
  parameter int            DW     = DW_DEF,
  parameter logic [AW-1:0] RST_PC = AW'(RST_PC_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          halt,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [AW-1:0] pc
);

  fetch_state_t  state_q, state_d;
  logic          mem_req_d, ir_valid_d, br_pend, br_pend_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] ir_d;
  logic          pc_ld, pc_inc;

  fetch_pc_reg #(.AW(AW), .RST_PC(RST_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .ld    (pc_ld),
    .inc   (pc_inc),
    .d     (br_target),
    .q     (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RST_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
      br_pend  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      ir       <= ir_d;
      ir_valid <= ir_valid_d;
      br_pend  <= br_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    ir_d       = ir;
    ir_valid_d = ir_valid;
    br_pend_d  = br_pend;
    pc_ld      = br_valid;
    pc_inc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = br_valid ? br_target : pc;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          // An ack for a request issued before a redirect is stale: drop it
          // and re-issue at the redirected PC.
          if (br_pend || br_valid) begin
            br_pend_d  = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = br_valid ? br_target : pc;
          end else begin
            ir_d       = mem_rdata;
            ir_valid_d = 1'b1;
            pc_inc     = 1'b1;
            mem_req_d  = 1'b0;
            state_d    = ST_HOLD;
          end
        end else if (br_valid) begin
          br_pend_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (br_valid || ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = halt ? ST_IDLE : ST_FETCH;
          mem_req_d  = !halt;
          mem_addr_d = br_valid ? br_target : pc;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        br_pend_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed self-checking bench for instr_fetch_seq.
module tb_instr_fetch_seq;

  logic        clk, reset, start, halt, br_valid, mem_ack, ir_ready;
  logic [15:0] br_target, mem_rdata;
  logic        mem_req, ir_valid;
  logic [15:0] mem_addr, ir, pc;

  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .halt      (halt),
    .br_valid  (br_valid),
    .br_target (br_target),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] st();
    return {14'b0, dut.state_q};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; br_valid = 1'b0; br_target = 16'h0;
    mem_ack = 1'b0; mem_rdata = 16'h0; ir_ready = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", {15'b0, mem_req}, 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_irv", {15'b0, ir_valid}, 16'd0);
    chk("rst_state", st(), 16'd0);
    reset = 1'b0;
    tick();

    // Two back-to-back fetches, decode always ready
    start = 1'b1; ir_ready = 1'b1;
    tick(); start = 1'b0;
    chk("f1_req", {15'b0, mem_req}, 16'd1);
    chk("f1_addr", mem_addr, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick(); mem_ack = 1'b0;
    chk("f1_irv", {15'b0, ir_valid}, 16'd1);
    chk("f1_ir", ir, 16'h1111);
    chk("f1_pc", pc, 16'h0001);
    chk("f1_req_hold", {15'b0, mem_req}, 16'd0);
    tick();
    chk("f2_req", {15'b0, mem_req}, 16'd1);
    chk("f2_addr", mem_addr, 16'h0001);
    chk("f2_irv", {15'b0, ir_valid}, 16'd0);
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick(); mem_ack = 1'b0;
    chk("f2_ir", ir, 16'h2222);
    chk("f2_irv", {15'b0, ir_valid}, 16'd1);
    chk("f2_pc", pc, 16'h0002);
    halt = 1'b1;
    tick(); halt = 1'b0; ir_ready = 1'b0;
    chk("f2_idle", st(), 16'd0);
    chk("f2_idle_req", {15'b0, mem_req}, 16'd0);

    // PC wrap from FFFF
    br_valid = 1'b1; br_target = 16'hFFFF;
    tick(); br_valid = 1'b0;
    chk("wr_pc", pc, 16'hFFFF);
    chk("wr_idle", st(), 16'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("wr_addr", mem_addr, 16'hFFFF);
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    tick(); mem_ack = 1'b0;
    chk("wr_pc0", pc, 16'h0000);
    chk("wr_ir", ir, 16'h3333);
    ir_ready = 1'b1;
    tick(); ir_ready = 1'b0;
    chk("wr_req", {15'b0, mem_req}, 16'd1);
    chk("wr_naddr", mem_addr, 16'h0000);

    // Branch during FETCH, stale ack three cycles later
    br_valid = 1'b1; br_target = 16'h0040;
    tick(); br_valid = 1'b0;
    chk("bf_pc", pc, 16'h0040);
    chk("bf_addr_held", mem_addr, 16'h0000);
    chk("bf_req", {15'b0, mem_req}, 16'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bf_wait_addr", mem_addr, 16'h0000);
      chk("bf_wait_irv", {15'b0, ir_valid}, 16'd0);
    end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick(); mem_ack = 1'b0;
    chk("bf_irv", {15'b0, ir_valid}, 16'd0);
    chk("bf_ir_kept", ir, 16'h3333);
    chk("bf_pc_noinc", pc, 16'h0040);
    chk("bf_req2", {15'b0, mem_req}, 16'd1);
    chk("bf_addr2", mem_addr, 16'h0040);
    chk("bf_state", st(), 16'd1);
    mem_ack = 1'b1; mem_rdata = 16'h4444;
    tick(); mem_ack = 1'b0;
    chk("bf_ir2", ir, 16'h4444);
    chk("bf_irv2", {15'b0, ir_valid}, 16'd1);
    chk("bf_pc2", pc, 16'h0041);

    // Branch and ir_ready together in HOLD
    br_valid = 1'b1; ir_ready = 1'b1; br_target = 16'h0100;
    tick(); br_valid = 1'b0; ir_ready = 1'b0;
    chk("bh_irv", {15'b0, ir_valid}, 16'd0);
    chk("bh_pc", pc, 16'h0100);
    chk("bh_req", {15'b0, mem_req}, 16'd1);
    chk("bh_addr", mem_addr, 16'h0100);

    // Decode stall in HOLD; acks there are ignored
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick(); mem_rdata = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_ir", ir, 16'h5555);
      chk("st_irv", {15'b0, ir_valid}, 16'd1);
      chk("st_req", {15'b0, mem_req}, 16'd0);
      chk("st_pc", pc, 16'h0101);
    end
    halt = 1'b1; ir_ready = 1'b1;
    tick(); halt = 1'b0; ir_ready = 1'b0;
    chk("ht_state", st(), 16'd0);
    chk("ht_irv", {15'b0, ir_valid}, 16'd0);
    chk("ht_ir_kept", ir, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ht_noreq", {15'b0, mem_req}, 16'd0);
      chk("ht_pc", pc, 16'h0101);
      chk("ht_irv_idle", {15'b0, ir_valid}, 16'd0);
    end
    mem_ack = 1'b0;

    // Reset with a read outstanding, ack arrives afterwards
    start = 1'b1;
    tick(); start = 1'b0;
    chk("rf_req", {15'b0, mem_req}, 16'd1);
    chk("rf_addr", mem_addr, 16'h0101);
    reset = 1'b1;
    #2;
    chk("rf_async_pc", pc, 16'h0000);
    tick(); reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick(); mem_ack = 1'b0;
    chk("rf_pc", pc, 16'h0000);
    chk("rf_irv", {15'b0, ir_valid}, 16'd0);
    chk("rf_state", st(), 16'd0);
    chk("rf_req_off", {15'b0, mem_req}, 16'd0);
    chk("rf_ir", ir, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
